gpi_debounce: RTL and testbench

// Conditions the raw board switch/button inputs (SW, BTN) before they reach the

---
 rtl/gpi_debounce_pkg.sv | 14 +
 rtl/gpi_debounce_chan.sv | 103 ++++++++++
 rtl/gpi_debounce.sv | 34 +++
 tb/tb_gpi_debounce.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gpi_debounce_pkg.sv
// Shared types and helpers for the GPI input conditioning path.
// Holds the per-channel state encoding and counter sizing.
package gpi_debounce_pkg;

    typedef enum logic {
        DbIdle,
        DbSettling
    } db_state_e;

    function automatic int db_cnt_width(int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpi_debounce_chan.sv
// One GPI channel: pad synchroniser, stability filter and edge pulses.
// The level only moves after DebounceCycles consecutive mismatching samples.
module gpi_debounce_chan
    import gpi_debounce_pkg::*;
#(
    parameter int   SyncStages     = 2,
    parameter int   DebounceCycles = 50000,
    parameter logic ResetVal       = 1'b0
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic raw_i,
    output logic gp_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CntW = db_cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [SyncStages-1:0] sync_q;
    logic                  syn;
    logic                  mismatch;

    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gp_q, gp_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            flip;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q <= {SyncStages{ResetVal}};
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], raw_i};
        end
    end

    assign syn      = sync_q[SyncStages-1];
    assign mismatch = syn ^ gp_q;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q <= DbIdle;
            cnt_q   <= '0;
            gp_q    <= ResetVal;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gp_q    <= gp_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gp_d    = gp_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        flip    = 1'b0;
        unique case (state_q)
            DbIdle: begin
                if (mismatch) begin
                    // A single-cycle filter accepts on the first differing sample
                    if (DebounceCycles == 1) begin
                        flip = 1'b1;
                    end else begin
                        state_d = DbSettling;
                        cnt_d   = CntOne;
                    end
                end
            end
            DbSettling: begin
                if (!mismatch) begin
                    state_d = DbIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    flip = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
        endcase
        if (flip) begin
            gp_d    = ~gp_q;
            rise_d  = ~gp_q;
            fall_d  = gp_q;
            state_d = DbIdle;
            cnt_d   = '0;
        end
    end

    assign gp_o   = gp_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpi_debounce.sv
// Board switch/button conditioning in front of the GPI bus.
// Every bit is an independent channel; this level only slices vectors.
module gpi_debounce
    import gpi_debounce_pkg::*;
#(
    parameter int               Width          = 8,
    parameter int               SyncStages     = 2,
    parameter int               DebounceCycles = 50000,
    parameter logic [Width-1:0] ResetValue     = '0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    for (genvar i = 0; i < Width; i++) begin : g_chan
        gpi_debounce_chan #(
            .SyncStages     (SyncStages),
            .DebounceCycles (DebounceCycles),
            .ResetVal       (ResetValue[i])
        ) u_chan (
            .clk_sys_i  (clk_sys_i),
            .rst_sys_ni (rst_sys_ni),
            .raw_i      (raw_i[i]),
            .gp_o       (gp_o[i]),
            .rise_o     (rise_o[i]),
            .fall_o     (fall_o[i])
        );
    end

endmodule

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce: directed scenarios plus random bouncing inputs,
// checked every cycle against a sample-window model (DebounceCycles 4 and 1).
module tb_gpi_debounce;

    logic       clk;
    logic       rst_n;
    logic [7:0] raw;
    logic [7:0] gp4, rise4, fall4;
    logic [7:0] gp1, rise1, fall1;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    gpi_debounce #(
        .Width(8), .SyncStages(2), .DebounceCycles(4), .ResetValue(8'h00)
    ) dut (
        .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw),
        .gp_o(gp4), .rise_o(rise4), .fall_o(fall4)
    );

    gpi_debounce #(
        .Width(8), .SyncStages(2), .DebounceCycles(1), .ResetValue(8'h00)
    ) dut1 (
        .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw),
        .gp_o(gp1), .rise_o(rise1), .fall_o(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: hist[m] is the raw value sampled m edges ago. After two sync
    // stages, the level flips once the last D filtered samples all differ.
    logic [7:0] hist [0:5];
    logic [7:0] m_gp4, m_r4, m_f4;
    logic [7:0] m_gp1, m_r1, m_f1;

    function automatic logic [7:0] all_diff(int d, logic [7:0] lvl);
        logic [7:0] acc;
        acc = 8'hFF;
        for (int j = 0; j < d; j++) acc &= hist[1+j] ^ lvl;
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) hist[i] <= 8'h00;
            m_gp4 <= 8'h00; m_r4 <= 8'h00; m_f4 <= 8'h00;
            m_gp1 <= 8'h00; m_r1 <= 8'h00; m_f1 <= 8'h00;
        end else begin
            for (int i = 5; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= raw;
            m_gp4 <= m_gp4 ^ all_diff(4, m_gp4);
            m_r4  <= all_diff(4, m_gp4) & ~m_gp4;
            m_f4  <= all_diff(4, m_gp4) & m_gp4;
            m_gp1 <= m_gp1 ^ all_diff(1, m_gp1);
            m_r1  <= all_diff(1, m_gp1) & ~m_gp1;
            m_f1  <= all_diff(1, m_gp1) & m_gp1;
        end
    end

    task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_gp4", gp4, m_gp4);
            chk("model_rise4", rise4, m_r4);
            chk("model_fall4", fall4, m_f4);
            chk("model_gp1", gp1, m_gp1);
            chk("model_rise1", rise1, m_r1);
            chk("model_fall1", fall1, m_f1);
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    logic [7:0] seen;
    logic [7:0] mask;

    initial begin
        rst_n = 1'b0;
        raw   = 8'hFF;
        tick(1);
        cmp_en = 1'b1;

        // 1: raw high through reset
        tick(2);
        neg(); chk("t1_rst_gp", gp4, 8'h00);
        chk("t1_rst_rise", rise4, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        neg(); chk("t1_d1_gp_early", gp1, 8'h00);
        tick(1);
        neg(); chk("t1_d1_gp", gp1, 8'hFF);
        tick(2);
        neg(); chk("t1_gp_early", gp4, 8'h00);
        tick(1);
        neg(); chk("t1_gp", gp4, 8'hFF);
        chk("t1_rise", rise4, 8'hFF);
        chk("t1_fall", fall4, 8'h00);
        tick(1);
        neg(); chk("t1_rise_end", rise4, 8'h00);

        // back to idle zero
        raw = 8'h00;
        tick(8);
        neg(); chk("t2_pre_gp", gp4, 8'h00);

        // 2: three-cycle pulse is rejected
        raw = 8'h01;
        tick(3);
        raw = 8'h00;
        seen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            neg();
            seen |= rise4 | fall4 | gp4;
        end
        chk("t2_reject", seen, 8'h00);

        // 3: bouncing then held high
        raw = 8'h02; tick(1);
        raw = 8'h00; tick(1);
        raw = 8'h02; tick(1);
        raw = 8'h00; tick(1);
        raw = 8'h02;
        tick(5);
        neg(); chk("t3_gp_early", gp4, 8'h00);
        tick(1);
        neg(); chk("t3_gp", gp4, 8'h02);
        chk("t3_rise", rise4, 8'h02);

        // 4: simultaneous rise and fall
        raw = 8'h08;
        tick(8);
        neg(); chk("t4_pre_gp", gp4, 8'h08);
        raw = 8'h04;
        tick(5);
        neg(); chk("t4_gp_early", gp4, 8'h08);
        tick(1);
        neg(); chk("t4_gp", gp4, 8'h04);
        chk("t4_rise", rise4, 8'h04);
        chk("t4_fall", fall4, 8'h08);

        // 5: reset while settling
        raw = 8'h14;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("t5_async_gp", gp4, 8'h00);
        chk("t5_async_fall", fall4, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        neg(); chk("t5_gp_early", gp4, 8'h00);
        tick(1);
        neg(); chk("t5_gp", gp4, 8'h14);
        chk("t5_rise", rise4, 8'h14);

        // 6: single-cycle filter passes a one-sample glitch
        raw = 8'h00;
        tick(10);
        raw = 8'h01;
        tick(2);
        neg(); chk("t6_gp1_early", gp1, 8'h00);
        tick(1);
        neg(); chk("t6_gp1", gp1, 8'h01);
        chk("t6_rise1", rise1, 8'h01);
        tick(4);
        raw = 8'h00;
        tick(1);
        raw = 8'h01;
        tick(2);
        neg(); chk("t6_glitch_fall", fall1, 8'h01);
        chk("t6_gp4_hold", gp4, 8'h01);
        tick(1);
        neg(); chk("t6_glitch_rise", rise1, 8'h01);

        // random bouncing with occasional resets
        for (int c = 0; c < 4000; c++) begin
            mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if (((c / 64) % 2) == 1) mask &= 8'($urandom) & 8'($urandom);
            raw ^= mask;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            tick(1);
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
